// File: rtl/dividend_rebuild.sv
`default_nettype none
// ============================================================================
// Module      : dividend_rebuild
// Description : Sequential multiply-add checker for a repeated-subtraction
//               divider. Rebuilds dividend = quotient * divisor + remainder
//               by repeated addition of the divisor onto the remainder.
//               Operands arrive on data_in in the order divisor, quotient,
//               remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module dividend_rebuild (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [15:0] dividend,
    output logic        done,
    output logic        busy,
    output logic        ovf,
    output logic        rem_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDB  = 3'd1,
        S_LDQ  = 3'd2,
        S_LDR  = 3'd3,
        S_ADD  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] b_q, b_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;
    logic        rem_err_q, rem_err_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    // 17-bit sum so the carry-out of each add is visible for the sticky flag.
    logic [16:0] w_sum;
    assign w_sum = {1'b0, acc_q} + {1'b0, b_q};

    // Next-state and datapath update; outputs are derived from the next state
    // so that done/busy come straight out of flops.
    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        rem_err_d = rem_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LDB;
                    ovf_d     = 1'b0;
                    rem_err_d = 1'b0;
                end
            end
            S_LDB: begin
                b_d     = data_in;
                state_d = S_LDQ;
            end
            S_LDQ: begin
                cnt_d   = data_in;
                state_d = S_LDR;
            end
            S_LDR: begin
                acc_d     = data_in;
                // A remainder not below the divisor (including divisor 0)
                // cannot come from a correct division.
                rem_err_d = (data_in >= b_q);
                state_d   = S_ADD;
            end
            S_ADD: begin
                if (cnt_q != 16'd0) begin
                    acc_d = w_sum[15:0];
                    ovf_d = ovf_q | w_sum[16];
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Stay here until start drops so a held request cannot
                // retrigger a new operation.
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_LDB) || (state_d == S_LDQ) ||
                 (state_d == S_LDR) || (state_d == S_ADD);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            b_q       <= 16'd0;
            cnt_q     <= 16'd0;
            acc_q     <= 16'd0;
            ovf_q     <= 1'b0;
            rem_err_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            rem_err_q <= rem_err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign dividend = acc_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;
    assign rem_err  = rem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dividend_rebuild.sv
`default_nettype none
// ============================================================================
// Module      : tb_dividend_rebuild
// Description : Scoreboard bench for dividend_rebuild. The driver pushes the
//               arithmetically expected result for each operation; a monitor
//               pops and compares when done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dividend_rebuild;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] dividend;
    logic        done;
    logic        busy;
    logic        ovf;
    logic        rem_err;

    dividend_rebuild u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .dividend (dividend),
        .done     (done),
        .busy     (busy),
        .ovf      (ovf),
        .rem_err  (rem_err)
    );

    typedef struct {
        logic [15:0] dividend;
        logic        ovf;
        logic        rem_err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges; read at the falling edge this equals the index of
    // the most recent rising edge.
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: busy/done exclusivity every cycle, result comparison on done rise.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_excl", {31'd0, busy & done}, 32'd0);
            if (done && !prev_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dividend", {16'd0, dividend}, {16'd0, e.dividend});
                    check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                    check("rem_err", {31'd0, rem_err}, {31'd0, e.rem_err});
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
        prev_done = done;
    end

    // Issue one operation; the expected outcome comes from plain arithmetic:
    // the true sum r + q*b reduced mod 2^16, overflow iff it exceeds 16 bits.
    task automatic run_op(input logic [15:0] b, input logic [15:0] q,
                          input logic [15:0] r, input bit hold);
        exp_t    e;
        longint  full;
        int      e0;
        int      n;
        @(negedge clk);
        start = 1'b1;
        e0 = cyc + 1;
        full = longint'(q) * longint'(b) + longint'(r);
        e.dividend = full[15:0];
        e.ovf      = (full > 64'sd65535);
        e.rem_err  = (r >= b);
        e.cyc      = e0 + 4 + int'(q);
        sb.push_back(e);
        @(negedge clk);                       // after E0
        data_in = b;
        start   = 1'($urandom);
        @(negedge clk);                       // after E1
        check("flags_clear_e1", {30'd0, ovf, rem_err}, 32'd0);
        data_in = q;
        start   = 1'($urandom);
        @(negedge clk);                       // after E2
        data_in = r;
        start   = 1'($urandom);
        @(negedge clk);                       // after E3
        check("rem_err_e3", {31'd0, rem_err}, {31'd0, e.rem_err});
        n = 0;
        while (!done) begin
            if (n > int'(q) + 20) begin
                check("done_timeout", 32'd0, 32'd1);
                sb.delete();
                break;
            end
            data_in = 16'($urandom);
            start   = 1'($urandom);
            @(negedge clk);
            n = n + 1;
        end
        start = hold;
    endtask

    initial begin
        logic [15:0] held;
        int          e0;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = 16'd0;
        #1;
        check("rst_dividend", {16'd0, dividend}, 32'd0);
        check("rst_flags", {28'd0, done, busy, ovf, rem_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the intended use.
        run_op(16'd3, 16'd1, 16'd1, 1'b0);
        run_op(16'd7, 16'd0, 16'd5, 1'b0);
        run_op(16'hFFFF, 16'd2, 16'd0, 1'b0);

        // Held start through DONE keeps the result frozen.
        run_op(16'd0, 16'd5, 16'd0, 1'b1);
        held = dividend;
        repeat (5) begin
            @(negedge clk);
            check("hold_done", {31'd0, done}, 32'd1);
            check("hold_dividend", {16'd0, dividend}, {16'd0, held});
            check("hold_rem_err", {31'd0, rem_err}, 32'd1);
        end
        start = 1'b0;
        run_op(16'd3, 16'd1, 16'd1, 1'b0);

        // Reset in the middle of ADD abandons the operation.
        @(negedge clk);
        start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk); data_in = 16'd1;   start = 1'b0;
        @(negedge clk); data_in = 16'd100;
        @(negedge clk); data_in = 16'd0;
        while (cyc < e0 + 20) @(negedge clk);
        check("mid_add_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_dividend", {16'd0, dividend}, 32'd0);
        check("async_rst_flags", {28'd0, done, busy, ovf, rem_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd2, 16'd3, 16'd1, 1'b0);

        // Randomized operations, mixing consistent and inconsistent inputs.
        for (int k = 0; k < 25; k++) begin
            logic [15:0] rb;
            logic [15:0] rq;
            logic [15:0] rr;
            case ($urandom_range(0, 3))
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 20));
                default: rb = 16'($urandom);
            endcase
            rq = 16'($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 0 && rb != 16'd0)
                rr = 16'($urandom_range(0, int'(rb) - 1));
            else
                rr = 16'($urandom);
            run_op(rb, rq, rr, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
